// File: rtl/uart_cmd_burst_ctrl_pkg.sv
// Shared types for the UART burst command controller: FSM state and command encodings,
// plus helpers that place the header fields from the top-level widths.
package uart_cmd_burst_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_DATA = 2'd1,
      ST_ISSUE     = 2'd2
   } state_e;

   localparam logic UART_CMD_WRITE = 1'b1;
   localparam logic UART_CMD_READ  = 1'b0;

   // Header layout: [cmd][dev][spare][len][addr], MSB first.
   function automatic int hdr_cmd_bit(input int word_w);
      return word_w - 1;
   endfunction

   function automatic int hdr_dev_msb(input int word_w);
      return word_w - 2;
   endfunction

   function automatic int hdr_len_lsb(input int mem_addr_w);
      return mem_addr_w;
   endfunction

   function automatic int hdr_spare_w(input int word_w, input int dev_w, input int len_w,
                                      input int mem_w);
      return word_w - 1 - dev_w - len_w - mem_w;
   endfunction

endpackage

// File: rtl/FFD_POSEDGE_SYNCRONOUS_RESET.sv
// Generic enable flop with synchronous active-high reset, shared across the codebase.
module FFD_POSEDGE_SYNCRONOUS_RESET #(
   parameter int SIZE = 1
)(
   input  logic            Clock,
   input  logic            Reset,
   input  logic            Enable,
   input  logic [SIZE-1:0] D,
   output logic [SIZE-1:0] Q
);

   always_ff @(posedge Clock) begin
      if (Reset)
         Q <= '0;
      else if (Enable)
         Q <= D;
   end

endmodule

// File: rtl/uart_cmd_hdr_decode.sv
// Pure field extractor for the 32-bit burst header word (cmd, dev, len, addr).
module uart_cmd_hdr_decode
   import uart_cmd_burst_ctrl_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int DEV_ADDR_W = 4,
   parameter int MEM_ADDR_W = 16,
   parameter int LEN_W      = 8
)(
   input  logic [WORD_W-1:0]     iWord,
   output logic                  oCmd,
   output logic [DEV_ADDR_W-1:0] oDev,
   output logic [LEN_W-1:0]      oLen,
   output logic [MEM_ADDR_W-1:0] oAddr
);

   localparam int CMD_BIT = hdr_cmd_bit(WORD_W);
   localparam int DEV_MSB = hdr_dev_msb(WORD_W);
   localparam int LEN_LSB = hdr_len_lsb(MEM_ADDR_W);
   localparam int SPARE_W = hdr_spare_w(WORD_W, DEV_ADDR_W, LEN_W, MEM_ADDR_W);

   assign oCmd  = iWord[CMD_BIT];
   assign oDev  = iWord[DEV_MSB -: DEV_ADDR_W];
   assign oLen  = iWord[LEN_LSB +: LEN_W];
   assign oAddr = iWord[MEM_ADDR_W-1:0];

   // Spare bits between len and dev are reserved and ignored.
   if (SPARE_W > 0) begin : g_spare
      logic [SPARE_W-1:0] unused_spare;
      assign unused_spare = iWord[LEN_LSB+LEN_W +: SPARE_W];
   end

endmodule

// File: rtl/uart_cmd_burst_ctrl.sv
// Burst command controller: decodes a UART header, then issues LEN+1 read or write commands
// with an auto-incrementing address. Optional write-data timeout: UART_CMD_TIMEOUT_EN.
module uart_cmd_burst_ctrl
   import uart_cmd_burst_ctrl_pkg::*;
#(
   parameter int WORD_W      = 32,
   parameter int DEV_ADDR_W  = 4,
   parameter int MEM_ADDR_W  = 16,
   parameter int LEN_W       = 8,
   parameter int TIMEOUT_CYC = 1000000
)(
   input  logic                  iClock,
   input  logic                  iReset,
   input  logic                  iWordValid,
   input  logic [WORD_W-1:0]     iWord,
   output logic                  oCmdValid,
   input  logic                  iCmdReady,
   output logic                  oCmdWrite,
   output logic [DEV_ADDR_W-1:0] oDevAddr,
   output logic [MEM_ADDR_W-1:0] oMemAddr,
   output logic [WORD_W-1:0]     oWriteData,
   output logic                  oBusy,
   output logic                  oDone,
   output logic                  oOverrun,
   output logic                  oTimeout
);

   if (1 + DEV_ADDR_W + LEN_W + MEM_ADDR_W > WORD_W) begin : g_bad_header
      $error("uart_cmd_burst_ctrl: header fields do not fit in WORD_W");
   end

   state_e                  state_q, state_d;
   logic                    cmd_q, cmd_d;
   logic [DEV_ADDR_W-1:0]   dev_q, dev_d;
   logic [WORD_W-1:0]       data_q, data_d;
   logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]        rem_q, rem_d;
   logic                    done_q, done_d;
   logic                    overrun_q, overrun_d;

   logic                    hdr_cmd;
   logic [DEV_ADDR_W-1:0]   hdr_dev;
   logic [LEN_W-1:0]        hdr_len;
   logic [MEM_ADDR_W-1:0]   hdr_addr;

`ifdef UART_CMD_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TMO_W-1:0]        tmo_q, tmo_d;
   logic                    timeout_q, timeout_d;
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

   uart_cmd_hdr_decode #(
      .WORD_W     (WORD_W),
      .DEV_ADDR_W (DEV_ADDR_W),
      .MEM_ADDR_W (MEM_ADDR_W),
      .LEN_W      (LEN_W)
   ) u_hdr_decode (
      .iWord (iWord),
      .oCmd  (hdr_cmd),
      .oDev  (hdr_dev),
      .oLen  (hdr_len),
      .oAddr (hdr_addr)
   );

   FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(1)) u_cmd_ff (
      .Clock(iClock), .Reset(iReset), .Enable(1'b1), .D(cmd_d), .Q(cmd_q)
   );

   FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(DEV_ADDR_W)) u_dev_ff (
      .Clock(iClock), .Reset(iReset), .Enable(1'b1), .D(dev_d), .Q(dev_q)
   );

   FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(WORD_W)) u_data_ff (
      .Clock(iClock), .Reset(iReset), .Enable(1'b1), .D(data_d), .Q(data_q)
   );

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      dev_d     = dev_q;
      data_d    = data_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      done_d    = 1'b0;
      overrun_d = 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_d     = tmo_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (iWordValid) begin
               cmd_d  = hdr_cmd;
               dev_d  = hdr_dev;
               addr_d = hdr_addr;
               rem_d  = hdr_len;
               if (hdr_cmd == UART_CMD_WRITE) begin
                  state_d = ST_WAIT_DATA;
`ifdef UART_CMD_TIMEOUT_EN
                  tmo_d   = '0;
`endif
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_WAIT_DATA: begin
            // A word on the terminal cycle wins over the timeout.
            if (iWordValid) begin
               data_d  = iWord;
               state_d = ST_ISSUE;
            end
`ifdef UART_CMD_TIMEOUT_EN
            else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         ST_ISSUE: begin
            overrun_d = iWordValid;
            if (iCmdReady) begin
               if (rem_q == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  addr_d = addr_q + 1'b1;
                  rem_d  = rem_q - 1'b1;
                  if (cmd_q == UART_CMD_WRITE) begin
                     state_d = ST_WAIT_DATA;
`ifdef UART_CMD_TIMEOUT_EN
                     tmo_d   = '0;
`endif
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

`ifdef UART_CMD_TIMEOUT_EN
   always_ff @(posedge iClock) begin
      if (iReset) begin
         tmo_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmo_q     <= tmo_d;
         timeout_q <= timeout_d;
      end
   end
   assign oTimeout = timeout_q;
`else
   assign oTimeout = 1'b0;
`endif

   // Valid/ready: a command is accepted on any cycle where oCmdValid && iCmdReady;
   // all command fields stay stable from the rise of oCmdValid until that cycle.
   assign oCmdValid  = (state_q == ST_ISSUE);
   assign oCmdWrite  = cmd_q;
   assign oDevAddr   = oCmdValid ? dev_q : '0;
   assign oMemAddr   = addr_q;
   assign oWriteData = data_q;
   assign oBusy      = (state_q != ST_IDLE);
   assign oDone      = done_q;
   assign oOverrun   = overrun_q;

endmodule

// File: tb/tb_uart_cmd_burst_ctrl.sv
// Randomized bench for uart_cmd_burst_ctrl: bursts are expanded into an expected command
// queue up front and matched against every accepted handshake.
module tb_uart_cmd_burst_ctrl;

  localparam int WORD_W      = 32;
  localparam int DEV_ADDR_W  = 4;
  localparam int MEM_ADDR_W  = 16;
  localparam int LEN_W       = 8;
  localparam int TIMEOUT_CYC = 16;
  localparam int EXP_W       = 1 + 1 + DEV_ADDR_W + MEM_ADDR_W + WORD_W;

  logic                  iClock;
  logic                  iReset;
  logic                  iWordValid;
  logic [WORD_W-1:0]     iWord;
  logic                  oCmdValid;
  logic                  iCmdReady;
  logic                  oCmdWrite;
  logic [DEV_ADDR_W-1:0] oDevAddr;
  logic [MEM_ADDR_W-1:0] oMemAddr;
  logic [WORD_W-1:0]     oWriteData;
  logic                  oBusy;
  logic                  oDone;
  logic                  oOverrun;
  logic                  oTimeout;

  uart_cmd_burst_ctrl #(
    .WORD_W      (WORD_W),
    .DEV_ADDR_W  (DEV_ADDR_W),
    .MEM_ADDR_W  (MEM_ADDR_W),
    .LEN_W       (LEN_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iWordValid (iWordValid),
    .iWord      (iWord),
    .oCmdValid  (oCmdValid),
    .iCmdReady  (iCmdReady),
    .oCmdWrite  (oCmdWrite),
    .oDevAddr   (oDevAddr),
    .oMemAddr   (oMemAddr),
    .oWriteData (oWriteData),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oOverrun   (oOverrun),
    .oTimeout   (oTimeout)
  );

  // ---------------- clock / reset ----------------
  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  initial begin
    #500000;
    $display("FAIL watchdog got=expired required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];   // {last, write, dev, addr, data}
  logic [WORD_W-1:0] fix_q[$];  // optional fixed write data for directed bursts
  int   hs_cnt = 0;
  logic pend_done = 1'b0;
  int   ready_mode = 0;         // 0: always ready, 1: random, 2: never, 3: 3 low / 1 high
  int   pat_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h required=%h", tag, got, exp);
    end
  endtask

  // ---------------- ready driver ----------------
  initial iCmdReady = 1'b0;
  always @(posedge iClock) begin
    #1;
    case (ready_mode)
      0:       iCmdReady = 1'b1;
      1:       iCmdReady = 1'($urandom_range(0, 1));
      2:       iCmdReady = 1'b0;
      default: iCmdReady = ((pat_cnt % 4) == 3);
    endcase
    pat_cnt++;
  end

  // ---------------- monitor / scoreboard ----------------
  logic       stall_prev = 1'b0;
  logic       bubble_prev = 1'b0;
  logic [52:0] saved_fields;

  always @(negedge iClock) begin
    logic [EXP_W-1:0] e;
    logic [52:0] got;
    if (iReset) begin
      stall_prev  = 1'b0;
      bubble_prev = 1'b0;
    end else begin
      if (pend_done || oDone) begin
        check("done", oDone, pend_done);
        if (pend_done) check("idle_at_done", oBusy, 0);
        pend_done = 1'b0;
      end
      if (bubble_prev) check("nobubble", oCmdValid, 1);
      bubble_prev = 1'b0;
      if (stall_prev)
        check("hold", {oCmdValid, oCmdWrite, oDevAddr, oMemAddr, oWriteData},
              {1'b1, saved_fields});
      stall_prev = 1'b0;
      if (oCmdValid && iCmdReady) begin
        if (exp_q.size() == 0) begin
          check("unexp_hs", 1, 0);
        end else begin
          e   = exp_q.pop_front();
          got = {oCmdWrite, oDevAddr, oMemAddr, (oCmdWrite ? oWriteData : '0)};
          check("cmd", got, e[52:0]);
          hs_cnt++;
          if (e[53])       pend_done   = 1'b1;
          else if (!e[52]) bubble_prev = 1'b1;
        end
      end else if (oCmdValid) begin
        stall_prev   = 1'b1;
        saved_fields = {oCmdWrite, oDevAddr, oMemAddr, oWriteData};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [WORD_W-1:0] w);
    @(posedge iClock); #1;
    iWordValid = 1'b1;
    iWord      = w;
    @(posedge iClock); #1;
    iWordValid = 1'b0;
    iWord      = $urandom;
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_cnt < target && n < 200) begin
      @(posedge iClock); #1;
      n++;
    end
    if (hs_cnt < target) check("hs_wait", hs_cnt, target);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || oBusy || pend_done) && n < 2000) begin
      @(posedge iClock); #1;
      n++;
    end
    check("burst_end", {exp_q.size(), 31'(oBusy)}, 0);
    check("dev_idle", oDevAddr, 0);
  endtask

  function automatic logic [WORD_W-1:0] make_hdr(input logic wr, input logic [3:0] dev,
                                                 input logic [15:0] addr, input logic [7:0] len);
    logic [WORD_W-1:0] h;
    h        = '0;
    h[31]    = wr;
    h[30:27] = dev;
    h[26:24] = 3'($urandom);
    h[23:16] = len;
    h[15:0]  = addr;
    return h;
  endfunction

  task automatic run_burst(input logic wr, input logic [3:0] dev, input logic [15:0] addr,
                           input logic [7:0] len, input int gap_max);
    logic [WORD_W-1:0] data_w[$];
    logic [WORD_W-1:0] d;
    logic [15:0]       a;
    int                base;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 16'(i);
      d = '0;
      if (wr) d = (fix_q.size() != 0) ? fix_q.pop_front() : $urandom;
      data_w.push_back(d);
      exp_q.push_back({(i == int'(len)), wr, dev, a, d});
    end
    base = hs_cnt;
    send_word(make_hdr(wr, dev, addr, len));
    if (!wr) begin
      @(negedge iClock);
      check("rd_lat", oCmdValid, 1);
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        repeat ($urandom_range(0, gap_max)) @(posedge iClock);
        send_word(data_w[i]);
        @(negedge iClock);
        check("wr_lat", oCmdValid, 1);
        if (i < int'(len)) wait_hs(base + i + 1);
      end
    end
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    iReset     = 1'b1;
    iWordValid = 1'b0;
    iWord      = '0;
    repeat (3) @(posedge iClock);
    @(negedge iClock);
    check("reset_out", {oCmdValid, oCmdWrite, oDevAddr, oMemAddr, oWriteData,
                        oBusy, oDone, oOverrun, oTimeout}, 0);
    @(posedge iClock); #1;
    iReset = 1'b0;

    // read burst, no backpressure: header 0x1005_0100
    ready_mode = 0;
    run_burst(1'b0, 4'd2, 16'h0100, 8'd5, 0);

    // write burst with 3-cycle stalls: header 0x9001_0020
    ready_mode = 3;
    fix_q.push_back(32'hDEAD_BEEF);
    fix_q.push_back(32'hCAFE_F00D);
    run_burst(1'b1, 4'd2, 16'h0020, 8'd1, 2);

    // address wrap
    ready_mode = 0;
    run_burst(1'b0, 4'd7, 16'hFFFF, 8'd1, 0);

    // overrun while the command is stalled
    ready_mode = 2;
    exp_q.push_back({1'b1, 1'b0, 4'd5, 16'h1234, 32'h0});
    send_word(make_hdr(1'b0, 4'd5, 16'h1234, 8'd0));
    @(negedge iClock);
    check("ovr_lat", oCmdValid, 1);
    send_word(32'hFFFF_FFFF);
    @(negedge iClock);
    check("overrun", oOverrun, 1);
    check("ovr_fields", {oCmdValid, oCmdWrite, oDevAddr, oMemAddr}, {1'b1, 1'b0, 4'd5, 16'h1234});
    @(negedge iClock);
    check("overrun_pulse", oOverrun, 0);
    ready_mode = 0;
    wait_idle();

`ifdef UART_CMD_TIMEOUT_EN
    // write header with no data
    ready_mode = 0;
    send_word(make_hdr(1'b1, 4'd1, 16'h0000, 8'd0));
    for (int i = 0; i < TIMEOUT_CYC; i++) begin
      @(negedge iClock);
      check("tmo_wait", {oTimeout, oCmdValid, oBusy}, 3'b001);
    end
    @(negedge iClock);
    check("tmo_pulse", {oTimeout, oCmdValid, oBusy}, 3'b100);
    @(negedge iClock);
    check("tmo_clear", oTimeout, 0);
`endif

    // reset during the 3rd read of a len=7 burst
    ready_mode = 0;
    for (int i = 0; i < 8; i++)
      exp_q.push_back({(i == 7), 1'b0, 4'd3, 16'h0400 + 16'(i), 32'h0});
    base = hs_cnt;
    send_word(make_hdr(1'b0, 4'd3, 16'h0400, 8'd7));
    wait_hs(base + 2);
    iReset = 1'b1;
    @(posedge iClock); #1;
    iReset = 1'b0;
    exp_q.delete();
    pend_done = 1'b0;
    @(negedge iClock);
    check("rst_mid", {oCmdValid, oCmdWrite, oDevAddr, oMemAddr, oWriteData,
                      oBusy, oDone, oOverrun, oTimeout}, 0);
    repeat (4) @(negedge iClock);
    check("rst_no_done", {oDone, oBusy}, 0);
    run_burst(1'b0, 4'd4, 16'h0010, 8'd2, 0);

    // maximum length read
    ready_mode = 0;
    run_burst(1'b0, 4'd9, 16'hFF80, 8'd255, 0);

    // random bursts
    for (int t = 0; t < 25; t++) begin
      logic [15:0] a;
      ready_mode = $urandom_range(0, 3) == 2 ? 3 : $urandom_range(0, 1);
      a = ($urandom_range(0, 3) == 0) ? (16'hFFFF - 16'($urandom_range(0, 3))) : 16'($urandom);
      run_burst(1'($urandom_range(0, 1)), 4'($urandom), a, 8'($urandom_range(0, 9)), 3);
    end

    repeat (3) @(posedge iClock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
